// File: rtl/byte_striping_pkg.sv
// Shared constants for the byte striping / joining pair: pad value, lane count
// and the helper that turns a data-lane count into a per-lane mask.
package byte_striping_pkg;

    localparam logic [7:0] PAD_BYTE  = 8'hF7;
    localparam int         NUM_LANES = 4;
    localparam int         IDX_W     = 2;

    // Bit n is set when lane n carries real data, i.e. n < count.
    function automatic logic [3:0] fill_mask(input logic [2:0] count);
        logic [3:0] m;
        for (int n = 0; n < 4; n++) begin
            m[n] = (3'(n) < count);
        end
        return m;
    endfunction

endpackage

// File: rtl/byte_striping_lane_counter.sv
// Modulo-4 lane index: advances on inc, returns to lane 0 on clr (clr wins).
module lane_counter
    import byte_striping_pkg::*;
(
    input  logic             clk,
    input  logic             reset_L,
    input  logic             inc,
    input  logic             clr,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_d;

    always_comb begin
        idx_d = idx_q;
        if (clr) begin
            idx_d = '0;
        end else if (inc) begin
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

    assign idx = idx_q;

endmodule

// File: rtl/byte_striping.sv
// Serial byte stream to 4 registered lanes; groups leave on the fourth byte or
// on flush, with unused lanes padded and flagged in lane_mask.
module byte_striping #(
    parameter logic [7:0] PAD_BYTE  = byte_striping_pkg::PAD_BYTE,
    parameter int         NUM_LANES = byte_striping_pkg::NUM_LANES
) (
    input  logic       clk,
    input  logic       reset_L,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       flush,
    output logic [7:0] Lane_0,
    output logic [7:0] Lane_1,
    output logic [7:0] Lane_2,
    output logic [7:0] Lane_3,
    output logic       valid_out,
    output logic [3:0] lane_mask,
    output logic [1:0] ctr_3
);

    // Handshake: no backpressure. data_in is taken on every rising edge with
    // valid_in=1; valid_out is a single-cycle strobe, lanes/mask hold afterwards.

    logic [1:0] idx;
    logic       emit;
    logic       inc;
    logic       clr;
    logic [2:0] count;

    logic [7:0] stage_q [NUM_LANES];
    logic [7:0] stage_d [NUM_LANES];
    logic [7:0] lane_q  [NUM_LANES];
    logic [7:0] lane_d  [NUM_LANES];
    logic [3:0] mask_q;
    logic [3:0] mask_d;
    logic       valid_q;

    lane_counter u_lane_counter (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (inc),
        .clr     (clr),
        .idx     (idx)
    );

    always_comb begin
        emit    = (valid_in && (idx == 2'd3)) || (flush && (valid_in || (idx != 2'd0)));
        count   = {1'b0, idx} + {2'b00, valid_in};
        inc     = valid_in && !emit;
        clr     = emit;
        stage_d = stage_q;
        lane_d  = lane_q;
        mask_d  = mask_q;
        if (valid_in) begin
            stage_d[idx] = data_in;
        end
        // The byte accepted in the emitting cycle goes straight to its lane.
        if (emit) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                lane_d[n] = (3'(n) < count) ? stage_d[n] : PAD_BYTE;
            end
            mask_d = byte_striping_pkg::fill_mask(count);
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            for (int n = 0; n < NUM_LANES; n++) begin
                stage_q[n] <= 8'h00;
                lane_q[n]  <= 8'h00;
            end
            mask_q  <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_LANES; n++) begin
                stage_q[n] <= stage_d[n];
                lane_q[n]  <= lane_d[n];
            end
            mask_q  <= mask_d;
            valid_q <= emit;
        end
    end

    assign Lane_0    = lane_q[0];
    assign Lane_1    = lane_q[1];
    assign Lane_2    = lane_q[2];
    assign Lane_3    = lane_q[3];
    assign valid_out = valid_q;
    assign lane_mask = mask_q;
    assign ctr_3     = idx;

endmodule

// File: tb/tb_byte_striping.sv
// Bench for byte_striping: directed vector table, hand-written corner
// sequences and random traffic against a queue-based group model.
module tb_byte_striping;

    localparam logic [7:0] PAD = 8'hF7;

    logic       clk;
    logic       reset_L;
    logic [7:0] data_in;
    logic       valid_in;
    logic       flush;
    logic [7:0] Lane_0, Lane_1, Lane_2, Lane_3;
    logic       valid_out;
    logic [3:0] lane_mask;
    logic [1:0] ctr_3;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    byte_striping dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .flush     (flush),
        .Lane_0    (Lane_0),
        .Lane_1    (Lane_1),
        .Lane_2    (Lane_2),
        .Lane_3    (Lane_3),
        .valid_out (valid_out),
        .lane_mask (lane_mask),
        .ctr_3     (ctr_3)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: bytes of the open group, plus last emitted group
    logic [7:0] exp_q[$];
    logic [7:0] m_lane [4];
    logic       m_valid;
    logic [3:0] m_mask;
    logic [1:0] m_ctr;

    function automatic void model_reset();
        exp_q.delete();
        for (int n = 0; n < 4; n++) m_lane[n] = 8'h00;
        m_valid = 1'b0;
        m_mask  = 4'b0000;
        m_ctr   = 2'd0;
    endfunction

    function automatic void model_step(input logic v, input logic f, input logic [7:0] d);
        m_valid = 1'b0;
        if (v) exp_q.push_back(d);
        if (exp_q.size() == 4 || (f && exp_q.size() > 0)) begin
            for (int n = 0; n < 4; n++) begin
                m_lane[n] = (n < exp_q.size()) ? exp_q[n] : PAD;
                m_mask[n] = (n < exp_q.size());
            end
            m_valid = 1'b1;
            exp_q.delete();
        end
        m_ctr = 2'(exp_q.size());
    endfunction

    // scoreboard compare
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else pass_cnt++;
    endtask

    function automatic logic [31:0] lanes();
        return {Lane_0, Lane_1, Lane_2, Lane_3};
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".lanes"}, lanes(), {m_lane[0], m_lane[1], m_lane[2], m_lane[3]});
        check({tag, ".valid"}, 32'(valid_out), 32'(m_valid));
        check({tag, ".mask"}, 32'(lane_mask), 32'(m_mask));
        check({tag, ".ctr"}, 32'(ctr_3), 32'(m_ctr));
    endtask

    // driver: one clock with the given inputs, inputs dropped after the edge
    task automatic cycle(input logic v, input logic f, input logic [7:0] d);
        valid_in = v;
        flush    = f;
        data_in  = d;
        @(posedge clk);
        #1;
        model_step(v, f, d);
        valid_in = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset_L = 1'b1;
    endtask

    typedef struct {
        logic        v;
        logic        f;
        logic [7:0]  d;
        logic        exp_vo;
        logic [31:0] exp_lanes;
        logic [3:0]  exp_mask;
        logic [1:0]  exp_ctr;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic f, input logic [7:0] d,
                                input logic vo, input logic [31:0] ln,
                                input logic [3:0] mk_mask, input logic [1:0] ct);
        vec_t r;
        r.v = v; r.f = f; r.d = d;
        r.exp_vo = vo; r.exp_lanes = ln; r.exp_mask = mk_mask; r.exp_ctr = ct;
        return r;
    endfunction

    vec_t tbl[$];

    initial begin
        int pulses;
        int last_pulse;
        int gap_bad;
        logic [31:0] last_grp;

        reset_L  = 1'b0;
        valid_in = 1'b0;
        flush    = 1'b0;
        data_in  = 8'h00;
        model_reset();
        #2;
        check("async_reset.lanes", lanes(), 32'h0);
        check("async_reset.valid", 32'(valid_out), 32'h0);
        check("async_reset.mask", 32'(lane_mask), 32'h0);
        check("async_reset.ctr", 32'(ctr_3), 32'h0);
        do_reset();

        // full group, partial flush, flush+valid, empty flush, idle gaps
        tbl.push_back(mk(1, 0, 8'h00, 0, 32'h00000000, 4'h0, 2'd1));
        tbl.push_back(mk(1, 0, 8'h01, 0, 32'h00000000, 4'h0, 2'd2));
        tbl.push_back(mk(1, 0, 8'h02, 0, 32'h00000000, 4'h0, 2'd3));
        tbl.push_back(mk(1, 0, 8'h04, 1, 32'h00010204, 4'hF, 2'd0));
        tbl.push_back(mk(0, 0, 8'h99, 0, 32'h00010204, 4'hF, 2'd0));
        tbl.push_back(mk(1, 0, 8'hA0, 0, 32'h00010204, 4'hF, 2'd1));
        tbl.push_back(mk(1, 0, 8'hA1, 0, 32'h00010204, 4'hF, 2'd2));
        tbl.push_back(mk(0, 1, 8'h55, 1, 32'hA0A1F7F7, 4'h3, 2'd0));
        tbl.push_back(mk(1, 0, 8'hB0, 0, 32'hA0A1F7F7, 4'h3, 2'd1));
        tbl.push_back(mk(1, 1, 8'hB1, 1, 32'hB0B1F7F7, 4'h3, 2'd0));
        tbl.push_back(mk(0, 1, 8'h66, 0, 32'hB0B1F7F7, 4'h3, 2'd0));
        tbl.push_back(mk(1, 0, 8'hC0, 0, 32'hB0B1F7F7, 4'h3, 2'd1));
        tbl.push_back(mk(1, 0, 8'hC1, 0, 32'hB0B1F7F7, 4'h3, 2'd2));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0, 0, 8'h77, 0, 32'hB0B1F7F7, 4'h3, 2'd2));
        tbl.push_back(mk(1, 0, 8'hC2, 0, 32'hB0B1F7F7, 4'h3, 2'd3));
        tbl.push_back(mk(1, 0, 8'hC3, 1, 32'hC0C1C2C3, 4'hF, 2'd0));
        tbl.push_back(mk(1, 0, 8'h60, 0, 32'hC0C1C2C3, 4'hF, 2'd1));
        tbl.push_back(mk(0, 1, 8'h00, 1, 32'h60F7F7F7, 4'h1, 2'd0));
        tbl.push_back(mk(1, 0, 8'h70, 0, 32'h60F7F7F7, 4'h1, 2'd1));
        tbl.push_back(mk(1, 0, 8'h71, 0, 32'h60F7F7F7, 4'h1, 2'd2));
        tbl.push_back(mk(1, 1, 8'h72, 1, 32'h707172F7, 4'h7, 2'd0));
        tbl.push_back(mk(1, 0, 8'h50, 0, 32'h707172F7, 4'h7, 2'd1));
        tbl.push_back(mk(1, 0, 8'h51, 0, 32'h707172F7, 4'h7, 2'd2));
        tbl.push_back(mk(1, 0, 8'h52, 0, 32'h707172F7, 4'h7, 2'd3));
        tbl.push_back(mk(1, 1, 8'h53, 1, 32'h50515253, 4'hF, 2'd0));
        tbl.push_back(mk(0, 0, 8'h00, 0, 32'h50515253, 4'hF, 2'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].v, tbl[i].f, tbl[i].d);
            check($sformatf("vec%0d.lanes", i), lanes(), tbl[i].exp_lanes);
            check($sformatf("vec%0d.valid", i), 32'(valid_out), 32'(tbl[i].exp_vo));
            check($sformatf("vec%0d.mask", i), 32'(lane_mask), 32'(tbl[i].exp_mask));
            check($sformatf("vec%0d.ctr", i), 32'(ctr_3), 32'(tbl[i].exp_ctr));
        end

        // streaming: 16 back-to-back bytes
        do_reset();
        pulses = 0;
        last_pulse = -1;
        gap_bad = 0;
        last_grp = 32'h0;
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'h10 + 8'(i));
            check_model($sformatf("stream%0d", i));
            if (valid_out) begin
                if (last_pulse >= 0 && i - last_pulse != 4) gap_bad++;
                last_pulse = i;
                pulses++;
                last_grp = lanes();
            end
        end
        check("stream.pulses", 32'(pulses), 32'd4);
        check("stream.gap_errors", 32'(gap_bad), 32'd0);
        check("stream.last_group", last_grp, 32'h1C1D1E1F);

        // reset mid-group, byte presented while reset held is dropped
        do_reset();
        cycle(1'b1, 1'b0, 8'hD0);
        cycle(1'b1, 1'b0, 8'hD1);
        check("midgrp.ctr_before", 32'(ctr_3), 32'd2);
        #2;
        reset_L = 1'b0;
        #1;
        model_reset();
        check("midgrp.rst_lanes", lanes(), 32'h0);
        check("midgrp.rst_valid", 32'(valid_out), 32'h0);
        check("midgrp.rst_mask", 32'(lane_mask), 32'h0);
        check("midgrp.rst_ctr", 32'(ctr_3), 32'h0);
        valid_in = 1'b1;
        data_in  = 8'hEE;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check("midgrp.held_ctr", 32'(ctr_3), 32'h0);
        reset_L = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 8'hE0 + 8'(i));
            check_model($sformatf("after_rst%0d", i));
            if (valid_out) pulses++;
        end
        cycle(1'b0, 1'b1, 8'h00);
        check_model("after_rst.flush_empty");
        if (valid_out) pulses++;
        check("after_rst.pulses", 32'(pulses), 32'd1);
        check("after_rst.group", lanes(), 32'hE0E1E2E3);

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 6) == 0),
                  8'($urandom_range(0, 255)));
            check_model($sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/byte_striping.md
BYTE_STRIPING -- requirements
Module: byte_striping

Interface
REQ-001 Parameter PAD_BYTE, default 8'hF7, SHALL be the byte value used to fill unused lanes on flush.
REQ-002 Parameter NUM_LANES, default 4, SHALL be the lane count; only the value 4 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset_L  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 data_in  input  8  SHALL be the serial byte stream.
REQ-006 valid_in  input  1  SHALL qualify data_in; a byte is accepted on every rising clk edge where valid_in=1.
REQ-007 flush  input  1  SHALL request emission of a partially filled group, padded with PAD_BYTE.
REQ-008 Lane_0..Lane_3  output  8 each  SHALL be the registered striped lanes.
REQ-009 valid_out  output  1  SHALL be a one-cycle pulse marking a new lane group on Lane_0..Lane_3.
REQ-010 lane_mask  output  4  SHALL flag, per lane (bit n = Lane_n), that the lane holds real data (1) rather than pad (0); it is valid with valid_out.
REQ-011 ctr_3  output  2  SHALL be the index of the lane that receives the next accepted byte.

Function
REQ-012 The first accepted byte of a group SHALL go to Lane_0, then Lane_1, Lane_2 and Lane_3, in order. ctr_3 SHALL select the staging slot.
REQ-013 ctr_3 SHALL increment modulo 4 on each accepted byte. It SHALL wrap from 3 to 0 on the fourth byte.
REQ-014 Timing when the fourth byte is accepted at edge N:
  - At edge N: Lane_0..Lane_3 load all four staged bytes.
  - After edge N: valid_out=1 and lane_mask=4'b1111 for exactly one cycle.
  - Latency is 1 cycle from acceptance of the last byte.
REQ-015 Lane_0..Lane_3 and lane_mask SHALL hold their values between emissions.
REQ-016 valid_out SHALL be 0 in every cycle without an emission.
REQ-017 Back-to-back operation: with valid_in held at 1, the block SHALL emit one group every 4 cycles with no lost or duplicated byte.
REQ-018 Flush with ctr_3=k (k>0) and valid_in=0:
  - Emit lanes 0..k-1 from staging and lanes k..3 as PAD_BYTE.
  - lane_mask SHALL have bits 0..k-1 set and all other bits clear.
  - ctr_3 SHALL return to 0.
  - valid_out SHALL pulse on the next cycle.
REQ-019 Flush and valid_in together with ctr_3=k:
  - The byte SHALL be accepted into lane k.
  - The group SHALL be emitted with k+1 data lanes and the rest padded.
  - If k=3, this is a normal full emission with lane_mask=4'b1111.
REQ-020 Flush with ctr_3=0 and valid_in=0 SHALL be ignored: no emission, no state change.
REQ-021 valid_in=0 with flush=0 SHALL leave the staging contents and ctr_3 unchanged, so a group may be filled across idle gaps.
REQ-022 Staging bytes SHALL never appear on the lane outputs before their group is emitted.

Reset
REQ-023 While reset_L=0, independent of clk, the outputs SHALL be:
  - Lane_0..Lane_3 = 8'h00
  - valid_out = 0
  - lane_mask = 4'b0000
  - ctr_3 = 2'b00
  - all staging registers = 8'h00
REQ-024 Reset asserted mid-group SHALL discard the partial group with no emission.
REQ-025 The first byte accepted after reset deassertion SHALL go to Lane_0.
REQ-026 Bytes presented in the cycle in which reset_L is 0 at the clock edge SHALL NOT be accepted.

Structure
REQ-027 PAD_BYTE (8'hF7) and NUM_LANES (4) SHALL be defined in a shared package or include used by byte_joining and byte_striping.
REQ-028 The modulo-4 index counter SHALL be a sub-module named lane_counter, with inputs clk, reset_L, inc and clr, and output idx[1:0].
REQ-029 The staging registers and output registers SHALL be implemented in byte_striping itself.

Verification
REQ-030 Full group: after reset, accept 8'h00, 8'h01, 8'h02, 8'h04 on consecutive cycles -> one cycle later Lane_0..3 = 00, 01, 02, 04, valid_out=1 for 1 cycle, lane_mask=1111.
REQ-031 Streaming: valid_in=1 for 16 cycles with data 8'h10 to 8'h1F -> 4 valid_out pulses, 4 cycles apart; the last group is Lane_0..3 = 1C, 1D, 1E, 1F.
REQ-032 Partial flush: accept 8'hA0, 8'hA1, then flush with valid_in=0 -> Lane_0..3 = A0, A1, F7, F7, lane_mask=0011, ctr_3=0.
REQ-033 Simultaneous flush and valid_in: accept 8'hB0, then flush and valid_in with 8'hB1 -> Lane_0..3 = B0, B1, F7, F7, lane_mask=0011.
REQ-034 Idle gaps and empty flush:
  - Accept 8'hC0 and 8'hC1, idle 5 cycles, then accept 8'hC2 and 8'hC3 -> a single emission C0, C1, C2, C3.
  - Flush with ctr_3=0 -> no valid_out pulse.
REQ-035 Reset mid-group: accept 8'hD0 and 8'hD1, pulse reset_L low asynchronously, then accept 8'hE0 to 8'hE3 -> all outputs read 0 during reset, and the only emission is E0, E1, E2, E3.
